// File: rtl/cpu_pkg.sv
// Shared encodings for the branch sequencer: CON FF condition codes and the
// sequencer FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    COND_ZR = 2'b00,
    COND_NZ = 2'b01,
    COND_PL = 2'b10,
    COND_MI = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Drives the CON FF handshake for conditional branches and computes the
// branch target PC; keeps saturating executed/taken statistics.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int OFF_W = 19,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             hold,
  input  logic [1:0]       cond,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             con_out,
  output logic [1:0]       cond_q,
  output logic             ra_out,
  output logic             con_in,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_next,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] tk_count
);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  offset_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_next_q;
  logic              taken_q;
  logic [PC_W-1:0]   target;
  logic              latch, commit, fin;

  // Two's-complement add wraps naturally at PC_W bits.
  assign target = pc_q + {{(PC_W-OFF_W){offset_q[OFF_W-1]}}, offset_q};

  // NOTE: every register, datapath included, is reset so outputs read 0 during clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      cond_q    <= '0;
      offset_q  <= '0;
      pc_q      <= '0;
      pc_next_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cond_q   <= cond;
        offset_q <= offset;
        pc_q     <= pc_in;
        taken_q  <= 1'b0;
      end
      if (commit) begin
        pc_next_q <= pc_next;
        taken_q   <= con_out;
      end
    end
  end

  // NOTE: all combinational outputs get a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    ra_out  = 1'b0;
    con_in  = 1'b0;
    pc_load = 1'b0;
    done    = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    fin     = 1'b0;
    taken   = taken_q;
    pc_next = pc_next_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !hold) begin
          latch   = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        ra_out = 1'b1;
        con_in = 1'b1;
        if (!hold) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Ra stays on the bus past the con_in falling edge.
        ra_out = 1'b1;
        if (!hold) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        taken   = con_out;
        pc_load = con_out;
        pc_next = con_out ? target : pc_q;
        if (!hold) begin
          commit  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done = 1'b1;
        if (!hold) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Statistics bump once on FIN exit, so a held FIN does not recount.
  sat_counter #(.W(CNT_W)) u_br_count (
    .clk   (clk),
    .clr   (clr),
    .inc   (fin),
    .clear (1'b0),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_tk_count (
    .clk   (clk),
    .clr   (clr),
    .inc   (fin && taken_q),
    .clear (1'b0),
    .count (tk_count)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases plus randomized
// branches against a transaction-level reference model.
module tb_branch_sequencer;
  import cpu_pkg::*;

  localparam int PC_W    = 32;
  localparam int OFF_W   = 19;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             hold;
  logic [1:0]       cond;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  pc_in;
  logic             con_out;
  logic [1:0]       cond_q;
  logic             ra_out;
  logic             con_in;
  logic             pc_load;
  logic [PC_W-1:0]  pc_next;
  logic             busy;
  logic             done;
  logic             taken;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_br = 0;
  int   exp_tk = 0;
  logic exp_taken = 1'b0;

  branch_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .hold     (hold),
    .cond     (cond),
    .offset   (offset),
    .pc_in    (pc_in),
    .con_out  (con_out),
    .cond_q   (cond_q),
    .ra_out   (ra_out),
    .con_in   (con_in),
    .pc_load  (pc_load),
    .pc_next  (pc_next),
    .busy     (busy),
    .done     (done),
    .taken    (taken),
    .br_count (br_count),
    .tk_count (tk_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".br_count"}, 32'(br_count), 32'(exp_br));
    check({tag, ".tk_count"}, 32'(tk_count), 32'(exp_tk));
  endtask

  // One complete branch. Phases 1..4 are EVAL, SETTLE, UPDATE, FIN; the
  // phase numbered hold_phase is stretched by hold_n held cycles.
  task automatic run_branch(input logic [1:0] c, input logic [OFF_W-1:0] off,
                            input logic [PC_W-1:0] pc, input logic con,
                            input int hold_phase, input int hold_n,
                            input bit extra_start);
    logic signed [OFF_W-1:0] soff;
    logic [PC_W-1:0]         tgt;
    int                      nk;
    soff = off;
    tgt  = pc + PC_W'(soff);

    @(negedge clk);
    start = 1'b1; hold = 1'b0; cond = c; offset = off; pc_in = pc;
    con_out = 1'($urandom);
    #1;
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.taken", 32'(taken), 32'(exp_taken));

    for (int p = 1; p <= 4; p++) begin
      nk = (p == hold_phase) ? hold_n : 0;
      for (int k = 0; k <= nk; k++) begin
        @(negedge clk);
        start   = extra_start && (p == 2);
        hold    = (k < nk);
        cond    = 2'($urandom);
        offset  = OFF_W'($urandom);
        pc_in   = $urandom;
        con_out = (p == 3) ? con : 1'($urandom);
        #1;
        check($sformatf("p%0d.busy", p), 32'(busy), 32'd1);
        check($sformatf("p%0d.cond_q", p), 32'(cond_q), 32'(c));
        check($sformatf("p%0d.ra_out", p), 32'(ra_out), 32'(p <= 2));
        check($sformatf("p%0d.con_in", p), 32'(con_in), 32'(p == 1));
        check($sformatf("p%0d.pc_load", p), 32'(pc_load), 32'((p == 3) && con));
        check($sformatf("p%0d.done", p), 32'(done), 32'(p == 4));
        check($sformatf("p%0d.taken", p), 32'(taken), 32'((p >= 3) ? con : 1'b0));
        if (p == 3 && con) check("update.pc_next", pc_next, tgt);
        check_counters($sformatf("p%0d", p));
      end
    end

    exp_br    = (exp_br < CNT_MAX) ? exp_br + 1 : CNT_MAX;
    if (con) exp_tk = (exp_tk < CNT_MAX) ? exp_tk + 1 : CNT_MAX;
    exp_taken = con;

    @(negedge clk);
    start = 1'b0; hold = 1'b0; con_out = 1'($urandom);
    #1;
    check("post.busy", 32'(busy), 32'd0);
    check("post.done", 32'(done), 32'd0);
    check("post.pc_load", 32'(pc_load), 32'd0);
    check("post.taken", 32'(taken), 32'(exp_taken));
    check_counters("post");
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; hold = 1'b0; cond = '0; offset = '0;
    pc_in = '0; con_out = 1'b0;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.cond_q", 32'(cond_q), 32'd0);
    check("rst.pc_next", pc_next, 32'd0);
    check("rst.taken", 32'(taken), 32'd0);
    check_counters("rst");
    @(negedge clk);
    clr = 1'b1;

    // brzr taken, brnz not taken, backward branch wrapping below zero.
    run_branch(COND_ZR, 19'h00010, 32'h0000_0100, 1'b1, 0, 0, 1'b0);
    run_branch(COND_NZ, 19'h00040, 32'h0000_0200, 1'b0, 0, 0, 1'b0);
    run_branch(COND_MI, 19'h7FFF8, 32'h0000_0004, 1'b1, 0, 0, 1'b0);
    check("wrap.pc_next", pc_next, 32'hFFFF_FFFC);

    // Three held cycles in EVAL stretch done out to cycle 7.
    run_branch(COND_PL, 19'h00123, 32'h0000_1000, 1'b1, 1, 3, 1'b0);

    // A second start while busy is ignored: exactly one done.
    run_branch(COND_ZR, 19'h00008, 32'h0000_0300, 1'b0, 0, 0, 1'b1);

    // Start while held in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; hold = 1'b1;
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
    #1;
    check("idlehold.busy", 32'(busy), 32'd0);

    // Reset during SETTLE aborts the branch at once.
    @(negedge clk);
    start = 1'b1; cond = COND_NZ; offset = 19'h00020; pc_in = 32'h0000_0500;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("abort.in_settle_ra", 32'(ra_out), 32'd1);
    clr = 1'b0;
    #1;
    exp_br = 0; exp_tk = 0; exp_taken = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ra_out", 32'(ra_out), 32'd0);
    check("abort.cond_q", 32'(cond_q), 32'd0);
    check("abort.pc_next", pc_next, 32'd0);
    check("abort.taken", 32'(taken), 32'd0);
    check_counters("abort");
    @(negedge clk);
    clr = 1'b1;
    run_branch(COND_NZ, 19'h00020, 32'h0000_0500, 1'b1, 0, 0, 1'b0);

    // Randomized branches drive both counters into saturation.
    for (int i = 0; i < 24; i++) begin
      run_branch(2'($urandom), OFF_W'($urandom), $urandom, 1'($urandom | (i < 16)),
                 int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                 1'($urandom));
    end
    check("sat.br_count", 32'(br_count), 32'(CNT_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
